// File: rtl/demux_tdm_1_16.sv
// rtl/demux_tdm_1_16.sv - 1-to-16 TDM demultiplexer with round-robin framing and direct addressing
//
// Round-robin mode (sel_mode=0): a frame_start beat opens a 16-beat frame
// that is collected into shadow slots. On the 16th beat the whole frame is
// copied to y in a single step, so y never shows a partial frame.
// Direct mode (sel_mode=1): each valid beat writes din straight to channel addr.
// sel_mode is only sampled in IDLE.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din[W-1:0]   serial data beat
//   din_valid    din is valid this cycle
//   frame_start  marks the beat as channel 0 of a new frame (round-robin only)
//   sel_mode     0 = round-robin, 1 = direct address
//   addr[3:0]    direct-mode channel select
//   y[16*W-1:0]  channel outputs, channel k at [k*W +: W]
//   ch_strobe    one-hot pulse for the channel written by the last accepted beat
//   frame_valid  one-cycle pulse when a complete frame lands on y
//   frame_err    one-cycle pulse when a partial frame is aborted by frame_start
//   cur_ch       channel the next round-robin beat will write
//   busy         high while collecting a frame

module demux_tdm_1_16 #(
    parameter int W = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    din,
    input  logic            din_valid,
    input  logic            frame_start,
    input  logic            sel_mode,
    input  logic [3:0]      addr,
    output logic [16*W-1:0] y,
    output logic [15:0]     ch_strobe,
    output logic            frame_valid,
    output logic            frame_err,
    output logic [3:0]      cur_ch,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DIRECT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [16*W-1:0] shadow;
    logic [16*W-1:0] shadow_nxt;

    // Beat decode produced alongside the next-state logic
    logic            acc_rr;     // beat accepted into a round-robin frame
    logic            acc_dir;    // beat accepted in direct mode
    logic            restart;    // frame_start aborting a partial frame
    logic [3:0]      wr_ch;      // channel written by the current beat

    logic            frame_done;
    logic [3:0]      cur_ch_nxt;
    logic [15:0]     strobe_nxt;

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cur_ch      <= 4'd0;
            shadow      <= '0;
            y           <= '0;
            ch_strobe   <= 16'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cur_ch      <= cur_ch_nxt;
            shadow      <= shadow_nxt;
            ch_strobe   <= strobe_nxt;
            frame_valid <= frame_done;
            frame_err   <= restart;
            if (frame_done) begin
                // shadow_nxt already holds the 16th beat, so the frame is
                // transferred complete on this edge
                y <= shadow_nxt;
            end else if (acc_dir) begin
                y[int'(wr_ch)*W +: W] <= din;
            end
        end
    end

    // Next-state logic and beat decode
    always_comb begin
        state_nxt = state;
        acc_rr    = 1'b0;
        acc_dir   = 1'b0;
        restart   = 1'b0;
        wr_ch     = cur_ch;
        case (state)
            ST_IDLE: begin
                if (sel_mode) begin
                    // A beat on the entry cycle is already a direct beat
                    state_nxt = ST_DIRECT;
                    acc_dir   = din_valid;
                    wr_ch     = addr;
                end else if (din_valid && frame_start) begin
                    state_nxt = ST_COLLECT;
                    acc_rr    = 1'b1;
                    wr_ch     = 4'd0;
                end
            end
            ST_COLLECT: begin
                if (din_valid) begin
                    acc_rr = 1'b1;
                    if (frame_start && cur_ch != 4'd0) begin
                        restart = 1'b1;
                        wr_ch   = 4'd0;
                    end else if (cur_ch == 4'd15) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DIRECT: begin
                wr_ch = addr;
                if (din_valid) begin
                    acc_dir = 1'b1;
                end else if (!sel_mode) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values
    always_comb begin
        busy       = (state == ST_COLLECT);
        frame_done = acc_rr && !restart && (state == ST_COLLECT) && (cur_ch == 4'd15);

        shadow_nxt = shadow;
        if (acc_rr) begin
            shadow_nxt[int'(wr_ch)*W +: W] = din;
        end

        // 4-bit increment wraps 15 -> 0 at the end of a frame; a restart or
        // a fresh start writes slot 0 and so lands on 1
        cur_ch_nxt = acc_rr ? (wr_ch + 4'd1) : cur_ch;

        strobe_nxt = (acc_rr || acc_dir) ? (16'd1 << wr_ch) : 16'd0;
    end

endmodule

// File: tb/tb_demux_tdm_1_16.sv
// tb/tb_demux_tdm_1_16.sv - directed self-checking bench for demux_tdm_1_16
module tb_demux_tdm_1_16;

    logic        clk;
    logic        rst_n;
    logic [0:0]  din;
    logic        din_valid;
    logic        frame_start;
    logic        sel_mode;
    logic [3:0]  addr;
    logic [15:0] y;
    logic [15:0] ch_strobe;
    logic        frame_valid;
    logic        frame_err;
    logic [3:0]  cur_ch;
    logic        busy;

    int errors;
    int checks;
    int fv_cnt;
    int fe_cnt;

    logic [15:0] pat;

    demux_tdm_1_16 #(.W(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .sel_mode    (sel_mode),
        .addr        (addr),
        .y           (y),
        .ch_strobe   (ch_strobe),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .cur_ch      (cur_ch),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_valid) fv_cnt++;
        if (frame_err) fe_cnt++;
    endtask

    task automatic beat(input logic d, input logic fs);
        din         = d;
        din_valid   = 1'b1;
        frame_start = fs;
        tick();
        din_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0; fv_cnt = 0; fe_cnt = 0;
        rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_start = 1'b0;
        sel_mode = 1'b0; addr = 4'd0;
        pat = 16'h800D;   // beats 1,0,1,1,0,...,0,1 with channel 0 first

        // Reset state
        #1;
        check("rst_y", y, 16'h0);
        check("rst_strobe", ch_strobe, 16'h0);
        check("rst_fv", frame_valid, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        check("rst_cur_ch", cur_ch, 4'd0);
        check("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Contiguous frame
        for (int i = 0; i < 16; i++) begin
            beat(pat[i], i == 0);
            check($sformatf("s1_strobe%0d", i), ch_strobe, 16'd1 << i);
            if (i < 15) begin
                check($sformatf("s1_y_hold%0d", i), y, 16'h0);
                check($sformatf("s1_cur_ch%0d", i), cur_ch, i + 1);
                check($sformatf("s1_busy%0d", i), busy, 1'b1);
                check($sformatf("s1_fv%0d", i), frame_valid, 1'b0);
            end
        end
        check("s1_y", y, 16'h800D);
        check("s1_fv", frame_valid, 1'b1);
        check("s1_cur_ch_wrap", cur_ch, 4'd0);
        check("s1_busy_end", busy, 1'b0);
        tick();
        check("s1_fv_one_cycle", frame_valid, 1'b0);
        check("s1_strobe_clear", ch_strobe, 16'h0);

        // Same frame with a 3-cycle gap after beat 5
        for (int i = 0; i < 5; i++) beat(pat[i], i == 0);
        for (int g = 0; g < 3; g++) begin
            tick();
            check($sformatf("s2_gap_fv%0d", g), frame_valid, 1'b0);
            check($sformatf("s2_gap_strobe%0d", g), ch_strobe, 16'h0);
            check($sformatf("s2_gap_cur_ch%0d", g), cur_ch, 4'd5);
            check($sformatf("s2_gap_busy%0d", g), busy, 1'b1);
        end
        for (int i = 5; i < 16; i++) beat(pat[i], 1'b0);
        check("s2_y", y, 16'h800D);
        check("s2_fv", frame_valid, 1'b1);

        // Abort after 7 beats, then 16 beats of 1
        tick();
        fv_cnt = 0; fe_cnt = 0;
        for (int i = 0; i < 7; i++) beat(1'b0, i == 0);
        beat(1'b1, 1'b1);
        check("s3_fe", frame_err, 1'b1);
        check("s3_restart_cur_ch", cur_ch, 4'd1);
        check("s3_restart_strobe", ch_strobe, 16'h0001);
        check("s3_y_hold", y, 16'h800D);
        for (int i = 1; i < 16; i++) beat(1'b1, 1'b0);
        check("s3_y", y, 16'hFFFF);
        check("s3_fv", frame_valid, 1'b1);
        tick();
        check("s3_fe_count", fe_cnt, 1);
        check("s3_fv_count", fv_cnt, 1);

        // Reset after beat 9, then a new frame from slot 0
        fe_cnt = 0;
        for (int i = 0; i < 9; i++) beat(1'b1, i == 0);
        #3 rst_n = 1'b0;
        #1;
        check("s5_y_async", y, 16'h0);
        check("s5_cur_ch_async", cur_ch, 4'd0);
        check("s5_strobe_async", ch_strobe, 16'h0);
        check("s5_busy_async", busy, 1'b0);
        check("s5_fe_async", frame_err, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        beat(pat[0], 1'b1);
        check("s5_restart_cur_ch", cur_ch, 4'd1);
        check("s5_restart_strobe", ch_strobe, 16'h0001);
        check("s5_restart_busy", busy, 1'b1);
        for (int i = 1; i < 16; i++) beat(pat[i], 1'b0);
        check("s5_y", y, 16'h800D);
        check("s5_fv", frame_valid, 1'b1);
        check("s5_fe_count", fe_cnt, 0);

        // Beats without frame_start in IDLE are ignored
        tick();
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 1'b0);
            check($sformatf("s6_strobe%0d", i), ch_strobe, 16'h0);
            check($sformatf("s6_busy%0d", i), busy, 1'b0);
            check($sformatf("s6_cur_ch%0d", i), cur_ch, 4'd0);
        end
        check("s6_y", y, 16'h800D);

        // Direct mode
        fv_cnt = 0; fe_cnt = 0;
        sel_mode = 1'b1; addr = 4'hA;
        beat(1'b1, 1'b0);
        check("s4_y_bit10", y, 16'h840D);
        check("s4_strobe", ch_strobe, 16'h0400);
        check("s4_cur_ch", cur_ch, 4'd0);
        addr = 4'h0;
        beat(1'b0, 1'b1);
        check("s4_y_bit0", y, 16'h840C);
        check("s4_strobe0", ch_strobe, 16'h0001);
        check("s4_busy", busy, 1'b0);
        sel_mode = 1'b0;
        tick();
        check("s4_fv_count", fv_cnt, 0);
        check("s4_fe_count", fe_cnt, 0);

        // Back in IDLE: sel_mode toggled mid-frame has no effect
        beat(1'b0, 1'b1);
        check("s7_busy", busy, 1'b1);
        sel_mode = 1'b1;
        for (int i = 1; i < 16; i++) beat(1'b0, 1'b0);
        sel_mode = 1'b0;
        check("s7_y", y, 16'h0);
        check("s7_fv", frame_valid, 1'b1);
        tick();
        check("s7_busy_end", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_tdm_1_16.md
DEMUX_TDM_1_16 -- requirements
Module: demux_tdm_1_16

Interface
REQ-001 The block SHALL have parameter W, default 1, giving the data width per channel in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port din, input, W bits: serial data beat.
REQ-005 The block SHALL have port din_valid, input, 1 bit: din is valid this cycle.
REQ-006 The block SHALL have port frame_start, input, 1 bit: qualifies the current valid beat as channel 0 of a new frame (round-robin mode only).
REQ-007 The block SHALL have port sel_mode, input, 1 bit: 0 means round-robin (TDM) mode; 1 means direct-address mode.
REQ-008 The block SHALL have port addr, input, 4 bits: direct-mode channel select; addr[3] is the MSB (a) and addr[0] is the LSB (d).
REQ-009 The block SHALL have port y, output, 16*W bits: channel outputs; channel k occupies bits [k*W +: W].
REQ-010 The block SHALL have port ch_strobe, output, 16 bits: one-hot pulse marking the channel written by the last accepted beat.
REQ-011 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse when a complete 16-beat frame has been transferred to y.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a partial frame is aborted.
REQ-013 The block SHALL have port cur_ch, output, 4 bits: the channel the next round-robin beat will write.
REQ-014 The block SHALL have port busy, output, 1 bit: high while in COLLECT.

Function
REQ-015 The block SHALL implement FSM states IDLE, COLLECT and DIRECT.
REQ-016 The block SHALL sample sel_mode only in IDLE; a change of sel_mode in any other state SHALL have no effect until the FSM returns to IDLE.
REQ-017 In IDLE with sel_mode=0, the block SHALL ignore din_valid beats that lack frame_start, with no output change and no frame_err.
REQ-018 In IDLE with sel_mode=0, din_valid=1 and frame_start=1, the block SHALL write din into shadow slot 0, set cur_ch to 1 and enter COLLECT.
REQ-019 In COLLECT, each din_valid beat SHALL write din into shadow slot cur_ch and increment cur_ch; cycles with din_valid=0 SHALL hold all state (gaps allowed, no timeout).
REQ-020 On the 16th beat (cur_ch=15), the block SHALL wrap cur_ch to 0, copy all 16 shadow slots to y atomically on the same edge, pulse frame_valid the following cycle and return to IDLE.
REQ-021 The block SHALL keep y stable during COLLECT, so that partial frames are never visible on y.
REQ-022 If din_valid=1 with frame_start=1 arrives in COLLECT with cur_ch≠0, the block SHALL pulse frame_err, discard the partial frame, treat the beat as slot 0 of a new frame, set cur_ch to 1 and stay in COLLECT.
REQ-023 In both modes, the block SHALL pulse the ch_strobe bit of the written channel for one cycle after each accepted beat; ch_strobe SHALL be 0 otherwise.
REQ-024 In IDLE with sel_mode=1, the block SHALL enter DIRECT; if din_valid=1 on that same cycle, the beat SHALL be processed as a DIRECT beat.
REQ-025 In DIRECT, each din_valid beat SHALL write din directly to y channel addr, visible one cycle later; frame_valid and frame_err SHALL never assert and frame_start SHALL be ignored.
REQ-026 The block SHALL leave DIRECT for IDLE on the first cycle with sel_mode=0 and din_valid=0.
REQ-027 The block SHALL have a latency of exactly 1 clock from an accepted beat to ch_strobe, from an accepted beat to the y update in DIRECT, and from the 16th beat to the y update in round-robin.
REQ-028 The block SHALL hold cur_ch at 0 in IDLE and DIRECT.

Reset
REQ-029 On assertion of rst_n=0, the block SHALL immediately and asynchronously clear y, the shadow slots, ch_strobe, frame_valid, frame_err and cur_ch to 0, drive busy to 0 and set the FSM to IDLE.
REQ-030 On deassertion of rst_n, the block SHALL accept a beat on the first rising edge with rst_n=1.
REQ-031 If reset asserts mid-frame, the block SHALL discard the partial frame without pulsing frame_err.

Verification
REQ-032 Bench scenario: W=1; frame_start with beats 1,0,1,1,0,0,0,0,0,0,0,0,0,0,0,1 (channel 0 first), contiguous -> y=16'h800D one cycle after beat 16, frame_valid high for exactly that cycle, ch_strobe walks 0001..8000.
REQ-033 Bench scenario: same frame with a 3-cycle din_valid gap after beat 5 -> identical y, frame_valid delayed 3 cycles, y unchanged until then.
REQ-034 Bench scenario: frame_start again after 7 beats, then 16 beats of 1 -> frame_err pulses once, final y=16'hFFFF, no frame_valid for the aborted frame.
REQ-035 Bench scenario: sel_mode=1, addr=4'hA, din=1 -> y bit 10 set next cycle, ch_strobe=16'h0400, frame_valid stays 0.
REQ-036 Bench scenario: rst_n low for 1 cycle after beat 9 -> outputs 0 asynchronously, frame_err stays 0, and the next frame_start beat restarts at slot 0.
REQ-037 Bench scenario: beats with frame_start=0 in IDLE -> no strobe, y unchanged, busy=0.
